// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access stage: op codes, FSM states,
// bus size codes and op-classification helpers.
package mem_access_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SIZE_HALF;
            EXE_LW_OP, EXE_SW_OP:             return SIZE_WORD;
            default:                          return SIZE_BYTE;
        endcase
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lane);
        case (op_size(op))
            SIZE_HALF: return lane[0];
            SIZE_WORD: return lane != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store strobe and data replication, load
// lane selection with sign or zero extension.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store strobe and replicated write data
    always_comb begin
        wstrb     = 4'h0;
        wdata_rep = wdata;
        case (op)
            EXE_SB_OP: begin
                wstrb     = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            EXE_SH_OP: begin
                wstrb     = 4'b0011 << {lane[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            EXE_SW_OP: wstrb = 4'hF;
            default:   wstrb = 4'h0;
        endcase
    end

    // Load lane select and extension
    always_comb begin
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (op)
            EXE_LB_OP:  load_ext = {{24{byte_s[7]}}, byte_s};
            EXE_LBU_OP: load_ext = {24'h0, byte_s};
            EXE_LH_OP:  load_ext = {{16{half_s[15]}}, half_s};
            EXE_LHU_OP: load_ext = {16'h0, half_s};
            default:    load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: accepts one load/store from EX/MEM, runs a
// request/response bus handshake, and retires it with a one-cycle done pulse.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  alucontrol,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_t      state_r, state_nxt_s;
    logic        cancel_r, cancel_nxt_s;
    logic [7:0]  op_r;
    logic [31:0] addr_r, wdata_r, load_data_r;
    logic [3:0]  wstrb_r;
    logic        wr_r;
    logic [1:0]  size_r;

    logic        live_s, mis_s, accept_s, kill_s, capture_s;
    logic [7:0]  align_op_s;
    logic [1:0]  align_lane_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_rep_s, load_ext_s;

    assign live_s   = ~rst & (state_r == ST_IDLE) & valid & ~flush
                    & (is_load(alucontrol) | is_store(alucontrol));
    assign mis_s    = misaligned(alucontrol, addr[1:0]);
    assign accept_s = live_s & ~mis_s;
    assign kill_s   = cancel_r | flush;

    // The aligner serves the incoming instruction in IDLE and the held one afterwards
    assign align_op_s   = (state_r == ST_IDLE) ? alucontrol : op_r;
    assign align_lane_s = (state_r == ST_IDLE) ? addr[1:0]  : addr_r[1:0];

    mem_align u_align (
        .op        (align_op_s),
        .lane      (align_lane_s),
        .wdata     (wdata),
        .rdata     (data_rdata),
        .wstrb     (wstrb_s),
        .wdata_rep (wdata_rep_s),
        .load_ext  (load_ext_s)
    );

    // Next-state, cancel tracking and load-capture decision
    always_comb begin
        state_nxt_s  = state_r;
        cancel_nxt_s = cancel_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cancel_nxt_s = 1'b0;
                if (accept_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_addr_ok && data_data_ok) begin
                    state_nxt_s  = kill_s ? ST_IDLE : ST_DONE;
                    cancel_nxt_s = 1'b0;
                    capture_s    = ~kill_s & is_load(op_r);
                end else if (data_addr_ok) begin
                    state_nxt_s  = ST_WAIT;
                    cancel_nxt_s = kill_s;
                end else if (flush) begin
                    state_nxt_s  = ST_IDLE;
                    cancel_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    state_nxt_s  = kill_s ? ST_IDLE : ST_DONE;
                    cancel_nxt_s = 1'b0;
                    capture_s    = ~kill_s & is_load(op_r);
                end else begin
                    state_nxt_s  = ST_WAIT;
                    cancel_nxt_s = kill_s;
                end
            end
            ST_DONE: begin
                state_nxt_s  = ST_IDLE;
                cancel_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                cancel_nxt_s = 1'b0;
            end
        endcase
    end

    // State, captured bus request and load result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cancel_r    <= 1'b0;
            op_r        <= 8'h00;
            addr_r      <= 32'h0;
            wdata_r     <= 32'h0;
            wstrb_r     <= 4'h0;
            wr_r        <= 1'b0;
            size_r      <= 2'd0;
            load_data_r <= 32'h0;
        end else begin
            state_r  <= state_nxt_s;
            cancel_r <= cancel_nxt_s;
            if (accept_s) begin
                op_r    <= alucontrol;
                addr_r  <= addr;
                wdata_r <= wdata_rep_s;
                wstrb_r <= wstrb_s;
                wr_r    <= is_store(alucontrol);
                size_r  <= op_size(alucontrol);
            end
            if (capture_s) begin
                load_data_r <= load_ext_s;
            end
        end
    end

    assign stall      = accept_s | (state_r == ST_REQ) | (state_r == ST_WAIT);
    assign done       = (state_r == ST_DONE);
    assign load_data  = load_data_r;
    assign adel       = live_s & mis_s & is_load(alucontrol);
    assign ades       = live_s & mis_s & is_store(alucontrol);
    assign badvaddr   = (live_s & mis_s) ? addr : 32'h0;
    assign data_req   = (state_r == ST_REQ);
    assign data_wr    = wr_r;
    assign data_size  = size_r;
    assign data_addr  = addr_r;
    assign data_wdata = wdata_r;
    assign data_wstrb = wstrb_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// transactions checked against a cycle-timeline reference model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst, valid, flush;
    logic [7:0]  alucontrol;
    logic [31:0] addr, wdata;
    logic        stall, done, adel, ades;
    logic [31:0] load_data, badvaddr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .valid(valid), .alucontrol(alucontrol),
        .addr(addr), .wdata(wdata), .flush(flush), .stall(stall), .done(done),
        .load_data(load_data), .adel(adel), .ades(ades), .badvaddr(badvaddr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic from the byte-lane rules
    function automatic bit m_load(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    function automatic int unsigned m_size(input logic [7:0] op);
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 2;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_loaded(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
        int unsigned b, h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (op)
            EXE_LB_OP:  return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            EXE_LBU_OP: return b;
            EXE_LH_OP:  return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            EXE_LHU_OP: return h;
            default:    return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [7:0] op, input logic [31:0] a);
        case (op)
            EXE_SB_OP: return 4'(1 << (a % 4));
            EXE_SH_OP: return 4'(3 << (2 * ((a / 2) % 2)));
            EXE_SW_OP: return 4'hF;
            default:   return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] wd);
        case (op)
            EXE_SB_OP: return (wd & 32'hFF) * 32'h0101_0101;
            EXE_SH_OP: return (wd & 32'hFFFF) * 32'h0001_0001;
            default:   return wd;
        endcase
    endfunction

    task automatic idle_inputs();
        valid = 1'b0; flush = 1'b0; alucontrol = 8'h00; addr = 32'h0; wdata = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One transaction; al/dl are addr_ok and data_ok delays, fl is the flush cycle (-1 none)
    task automatic do_txn(input string nm, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int al, input int dl, input int fl);
        int aok_c, dok_c, stall_end, done_c, req_end, last_c;
        bit early;
        aok_c  = 1 + al;
        dok_c  = aok_c + dl;
        early  = (fl >= 1) && (fl < aok_c);
        if (early) begin
            stall_end = fl; req_end = fl; done_c = -1;
        end else begin
            stall_end = dok_c; req_end = aok_c;
            done_c = (fl >= 1 && fl <= dok_c) ? -1 : dok_c + 1;
        end
        last_c = stall_end + 2;
        for (int c = 0; c <= last_c; c++) begin
            valid        = (c <= stall_end) || (c == done_c);
            alucontrol   = op;
            addr         = a;
            wdata        = wd;
            flush        = (c == fl);
            data_addr_ok = !early && (c == aok_c);
            data_data_ok = !early && (c == dok_c);
            data_rdata   = (c == dok_c) ? rd : $urandom;
            #1;
            check_eq({nm, ".stall"}, 32'(stall), 32'(c <= stall_end));
            check_eq({nm, ".req"}, 32'(data_req), 32'(c >= 1 && c <= req_end));
            check_eq({nm, ".done"}, 32'(done), 32'(c == done_c));
            if (c == 0) check_eq({nm, ".exc"}, {30'h0, adel, ades}, 32'h0);
            if (c >= 1 && c <= req_end) begin
                check_eq({nm, ".addr"}, data_addr, a);
                check_eq({nm, ".wr"}, 32'(data_wr), 32'(!m_load(op)));
                check_eq({nm, ".size"}, 32'(data_size), m_size(op));
                check_eq({nm, ".wstrb"}, 32'(data_wstrb), 32'(m_strb(op, a)));
                if (!m_load(op)) check_eq({nm, ".wdata"}, data_wdata, m_wdata(op, wd));
            end
            if (c == done_c && m_load(op)) check_eq({nm, ".load"}, load_data, m_loaded(op, a, rd));
            next_cycle();
        end
        idle_inputs();
    endtask

    // Misaligned access or non-memory op: no bus activity, single-cycle exception
    task automatic do_nobus(input string nm, input logic [7:0] op, input logic [31:0] a, input bit fault);
        valid = 1'b1; alucontrol = op; addr = a; wdata = $urandom;
        #1;
        check_eq({nm, ".adel"}, 32'(adel), 32'(fault && m_load(op)));
        check_eq({nm, ".ades"}, 32'(ades), 32'(fault && !m_load(op)));
        if (fault) check_eq({nm, ".badva"}, badvaddr, a);
        check_eq({nm, ".stall"}, 32'(stall), 32'h0);
        next_cycle();
        idle_inputs();
        #1;
        check_eq({nm, ".req1"}, 32'(data_req), 32'h0);
        check_eq({nm, ".done1"}, 32'(done), 32'h0);
        check_eq({nm, ".exc1"}, {30'h0, adel, ades}, 32'h0);
        next_cycle();
    endtask

    logic [7:0] ops [8];
    logic [7:0] op;
    logic [31:0] a;
    int sz, fl, al, dl;

    initial begin
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        check_eq("rst.ctl", {26'h0, stall, done, adel, ades, data_req, data_wr}, 32'h0);
        check_eq("rst.load", load_data, 32'h0);
        check_eq("rst.badva", badvaddr, 32'h0);
        check_eq("rst.addr", data_addr, 32'h0);
        check_eq("rst.wdata", data_wdata, 32'h0);
        check_eq("rst.strb_size", {26'h0, data_wstrb, data_size}, 32'h0);
        rst = 1'b0;
        next_cycle();

        do_txn("sw_dir", EXE_SW_OP, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 2, -1);
        do_txn("lb_dir", EXE_LB_OP, 32'h2000_0003, 32'h0, 32'h80AA_BBCC, 1, 1, -1);
        do_txn("lbu_dir", EXE_LBU_OP, 32'h2000_0003, 32'h0, 32'h80AA_BBCC, 0, 1, -1);
        do_txn("sh_dir", EXE_SH_OP, 32'h3000_0002, 32'h1234_5678, 32'h0, 0, 1, -1);
        do_nobus("lw_mis", EXE_LW_OP, 32'h4000_0006, 1'b1);
        do_nobus("sh_mis", EXE_SH_OP, 32'h4000_0001, 1'b1);
        do_nobus("nonmem", 8'h21, 32'h4000_0003, 1'b0);
        do_txn("lw_flush_wait", EXE_LW_OP, 32'h5000_0000, 32'h0, 32'h1111_2222, 0, 3, 2);
        do_txn("lh_same", EXE_LH_OP, 32'h6000_0000, 32'h0, 32'h0000_7FFF, 0, 0, -1);
        do_txn("lw_flush_req", EXE_LW_OP, 32'h7000_0008, 32'h0, 32'h0, 2, 1, 1);
        do_txn("sb_flush_aok", EXE_SB_OP, 32'h7000_0001, 32'hA5, 32'h0, 1, 1, 2);

        // Reset abandons an outstanding read; its late data_ok must not retire it
        valid = 1'b1; alucontrol = EXE_LW_OP; addr = 32'h8000_0000;
        next_cycle();
        valid = 1'b0; data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        #1;
        check_eq("rst_mid.stall", 32'(stall), 32'h0);
        check_eq("rst_mid.req", 32'(data_req), 32'h0);
        next_cycle();
        data_data_ok = 1'b0;
        #1;
        check_eq("rst_mid.done", 32'(done), 32'h0);
        check_eq("rst_mid.load", load_data, 32'h0);
        next_cycle();

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 7)];
            sz = m_size(op);
            a  = $urandom;
            if (sz == 1) a[0] = 1'b0;
            if (sz == 2) a[1:0] = 2'b00;
            al = $urandom_range(0, 3);
            dl = $urandom_range(0, 3);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + al + dl) : -1;
            do_txn("rand", op, a, $urandom, $urandom, al, dl, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
